// File: rtl/data_mem_bank.sv
// Multi-port data memory for the MIPS datapath: registered read ports, one byte-masked
// write port with write-first bypass, and a sweep-clear sequencer that zeroes the array.
module data_mem_bank #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4,
  parameter int NUM_RD = 2
) (
  input  logic                       clk,
  input  logic                       clear_n,
  input  logic                       init,
  output logic                       busy,
  input  logic                       wr_en,
  input  logic [ADDR_W-1:0]          wr_addr,
  input  logic [DATA_W/8-1:0]        wr_be,
  input  logic [DATA_W-1:0]          wr_data,
  input  logic [NUM_RD-1:0]          rd_en,
  input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
  output logic [NUM_RD*DATA_W-1:0]   rd_data,
  output logic [NUM_RD-1:0]          rd_valid
);

  localparam int DEPTH  = 2 ** ADDR_W;
  localparam int NBYTES = DATA_W / 8;
  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  typedef enum logic {SWEEP, IDLE} state_t;

  state_t            state;
  logic [ADDR_W-1:0] cnt;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] wr_word;
  logic [DATA_W-1:0] rd_word [NUM_RD];

  // The merged write word doubles as the bypass value, so a read that hits the write
  // address sees exactly what will land in the array.
  always_comb begin
    wr_word = mem[wr_addr];
    for (int i = 0; i < NBYTES; i++) begin
      if (wr_be[i]) wr_word[8*i +: 8] = wr_data[8*i +: 8];
    end
    for (int p = 0; p < NUM_RD; p++) begin
      if (wr_en && (wr_addr == rd_addr[p*ADDR_W +: ADDR_W]))
        rd_word[p] = wr_word;
      else
        rd_word[p] = mem[rd_addr[p*ADDR_W +: ADDR_W]];
    end
  end

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      state    <= SWEEP;
      cnt      <= '0;
      busy     <= 1'b1;
      rd_data  <= '0;
      rd_valid <= '0;
    end else begin
      case (state)
        SWEEP: begin
          cnt      <= cnt + 1'b1;
          rd_valid <= '0;
          if (cnt == LAST_ADDR) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        IDLE: begin
          for (int p = 0; p < NUM_RD; p++) begin
            if (rd_en[p]) rd_data[p*DATA_W +: DATA_W] <= rd_word[p];
          end
          rd_valid <= rd_en;
          if (init) begin
            state <= SWEEP;
            cnt   <= '0;
            busy  <= 1'b1;
          end
        end
        default: begin
          state <= SWEEP;
          cnt   <= '0;
          busy  <= 1'b1;
        end
      endcase
    end
  end

  // The array itself is never reset; the sweep owns the write port until it finishes.
  always_ff @(posedge clk) begin
    if (state == SWEEP)
      mem[cnt] <= '0;
    else if (wr_en)
      mem[wr_addr] <= wr_word;
  end

endmodule

// File: tb/tb_data_mem_bank.sv
// Directed self-checking bench for data_mem_bank (DATA_W=16, ADDR_W=4, NUM_RD=2).
module tb_data_mem_bank;

  logic        clk;
  logic        clear_n;
  logic        init;
  logic        busy;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [1:0]  wr_be;
  logic [15:0] wr_data;
  logic [1:0]  rd_en;
  logic [7:0]  rd_addr;
  logic [31:0] rd_data;
  logic [1:0]  rd_valid;

  int n_checks;
  int n_fails;

  data_mem_bank #(.DATA_W(16), .ADDR_W(4), .NUM_RD(2)) dut (
    .clk(clk), .clear_n(clear_n), .init(init), .busy(busy),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_be(wr_be), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1ns after each rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    init = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_be = '0; wr_data = '0;
    rd_en = '0; rd_addr = '0;
  endtask

  task automatic test_reset();
    int n;
    clear_n = 1'b0;
    idle_inputs();
    cyc(); cyc();
    n_checks++;
    if (busy !== 1'b1 || rd_valid !== 2'b00 || rd_data !== 32'h0) begin
      n_fails++;
      $display("[TB] FAIL reset_state: busy=%b valid=%b data=%h, want busy=1 valid=00 data=0",
               busy, rd_valid, rd_data);
    end
    clear_n = 1'b1;
    n = 0;
    while (busy === 1'b1 && n < 40) begin
      cyc();
      n++;
    end
    n_checks++;
    if (n !== 16) begin
      n_fails++;
      $display("[TB] FAIL reset_sweep_len: busy cycles=%0d, want 16", n);
    end
    for (int a = 0; a < 16; a++) begin
      rd_en = 2'b11;
      rd_addr = {4'(15 - a), 4'(a)};
      cyc();
      n_checks++;
      if (rd_data !== 32'h0 || rd_valid !== 2'b11) begin
        n_fails++;
        $display("[TB] FAIL swept_read addr=%0d: data=%h valid=%b, want data=0 valid=11",
                 a, rd_data, rd_valid);
      end
    end
    idle_inputs();
    cyc();
  endtask

  task automatic test_write_read();
    wr_en = 1'b1; wr_addr = 4'd3; wr_be = 2'b11; wr_data = 16'h1234;
    cyc();
    idle_inputs();
    rd_en = 2'b01; rd_addr = 8'h03;
    cyc();
    n_checks++;
    if (rd_data[15:0] !== 16'h1234 || rd_valid !== 2'b01) begin
      n_fails++;
      $display("[TB] FAIL write_read: data0=%h valid=%b, want 1234 valid=01",
               rd_data[15:0], rd_valid);
    end
    idle_inputs();
  endtask

  task automatic test_bypass();
    wr_en = 1'b1; wr_addr = 4'd5; wr_be = 2'b11; wr_data = 16'hAAAA;
    cyc();
    wr_addr = 4'd5; wr_be = 2'b01; wr_data = 16'h0055;
    rd_en = 2'b10; rd_addr = 8'h50;
    cyc();
    n_checks++;
    if (rd_data[31:16] !== 16'hAA55 || rd_valid !== 2'b10) begin
      n_fails++;
      $display("[TB] FAIL bypass_lo_byte: data1=%h valid=%b, want AA55 valid=10",
               rd_data[31:16], rd_valid);
    end
    wr_en = 1'b0;
    cyc();
    n_checks++;
    if (rd_data[31:16] !== 16'hAA55) begin
      n_fails++;
      $display("[TB] FAIL stored_merge: data1=%h, want AA55", rd_data[31:16]);
    end
    // Upper-byte-only bypass on port 0 into a zeroed word.
    wr_en = 1'b1; wr_addr = 4'd9; wr_be = 2'b10; wr_data = 16'hBEEF;
    rd_en = 2'b01; rd_addr = 8'h09;
    cyc();
    n_checks++;
    if (rd_data[15:0] !== 16'hBE00) begin
      n_fails++;
      $display("[TB] FAIL bypass_hi_byte: data0=%h, want BE00", rd_data[15:0]);
    end
    // An all-zero byte mask must leave the word alone, bypass included.
    wr_addr = 4'd3; wr_be = 2'b00; wr_data = 16'hFFFF;
    rd_en = 2'b01; rd_addr = 8'h03;
    cyc();
    wr_en = 1'b0;
    cyc();
    n_checks++;
    if (rd_data[15:0] !== 16'h1234) begin
      n_fails++;
      $display("[TB] FAIL be_zero_noop: data0=%h, want 1234", rd_data[15:0]);
    end
    idle_inputs();
  endtask

  task automatic test_dual_read();
    rd_en = 2'b11; rd_addr = 8'h53;
    cyc();
    n_checks++;
    if (rd_data !== 32'hAA55_1234 || rd_valid !== 2'b11) begin
      n_fails++;
      $display("[TB] FAIL dual_read: data=%h valid=%b, want AA551234 valid=11", rd_data, rd_valid);
    end
    rd_en = 2'b00; rd_addr = 8'h90;
    cyc();
    n_checks++;
    if (rd_data !== 32'hAA55_1234 || rd_valid !== 2'b00) begin
      n_fails++;
      $display("[TB] FAIL read_hold: data=%h valid=%b, want AA551234 valid=00", rd_data, rd_valid);
    end
    rd_en = 2'b11; rd_addr = 8'h99;
    cyc();
    n_checks++;
    if (rd_data !== 32'hBE00_BE00) begin
      n_fails++;
      $display("[TB] FAIL same_addr_read: data=%h, want BE00BE00", rd_data);
    end
    rd_en = 2'b11; rd_addr = 8'h53;
    cyc();
    idle_inputs();
    cyc();
  endtask

  task automatic test_back_to_back();
    wr_en = 1'b1; wr_addr = 4'd1; wr_be = 2'b11; wr_data = 16'h1111;
    cyc();
    wr_addr = 4'd2; wr_data = 16'h2222;
    rd_en = 2'b01; rd_addr = 8'h01;
    cyc();
    n_checks++;
    if (rd_data[15:0] !== 16'h1111) begin
      n_fails++;
      $display("[TB] FAIL b2b_first: data0=%h, want 1111", rd_data[15:0]);
    end
    wr_en = 1'b0;
    rd_en = 2'b10; rd_addr = 8'h20;
    cyc();
    n_checks++;
    if (rd_data !== 32'h2222_1111 || rd_valid !== 2'b10) begin
      n_fails++;
      $display("[TB] FAIL b2b_second: data=%h valid=%b, want 22221111 valid=10", rd_data, rd_valid);
    end
    // Leave known values in the read registers for the hold check during the sweep.
    rd_en = 2'b11; rd_addr = 8'h53;
    cyc();
    idle_inputs();
  endtask

  task automatic test_init_sweep();
    int n;
    int bad_valid;
    // init and a write in the same cycle: the write lands, then gets swept.
    init = 1'b1; wr_en = 1'b1; wr_addr = 4'd7; wr_be = 2'b11; wr_data = 16'h7777;
    cyc();
    init = 1'b0;
    n_checks++;
    if (busy !== 1'b1) begin
      n_fails++;
      $display("[TB] FAIL init_busy: busy=%b, want 1", busy);
    end
    n = 0;
    bad_valid = 0;
    while (busy === 1'b1 && n < 40) begin
      if (rd_valid !== 2'b00) bad_valid++;
      wr_en = 1'b1; wr_addr = 4'd7; wr_data = 16'h5A5A; wr_be = 2'b11;
      rd_en = 2'b11; rd_addr = 8'h37;
      cyc();
      n++;
    end
    idle_inputs();
    n_checks++;
    if (n !== 16) begin
      n_fails++;
      $display("[TB] FAIL init_sweep_len: busy cycles=%0d, want 16", n);
    end
    n_checks++;
    if (bad_valid !== 0) begin
      n_fails++;
      $display("[TB] FAIL valid_in_sweep: cycles with rd_valid set=%0d, want 0", bad_valid);
    end
    n_checks++;
    if (rd_data !== 32'hAA55_1234) begin
      n_fails++;
      $display("[TB] FAIL data_hold_sweep: data=%h, want AA551234", rd_data);
    end
    rd_en = 2'b11; rd_addr = 8'h37;
    cyc();
    n_checks++;
    if (rd_data !== 32'h0 || rd_valid !== 2'b11) begin
      n_fails++;
      $display("[TB] FAIL post_sweep_read: data=%h valid=%b, want 0 valid=11", rd_data, rd_valid);
    end
    idle_inputs();
    cyc();
  endtask

  task automatic test_reset_mid_sweep();
    int n;
    wr_en = 1'b1; wr_addr = 4'd4; wr_be = 2'b11; wr_data = 16'hCAFE;
    rd_en = 2'b01; rd_addr = 8'h04;
    cyc();
    idle_inputs();
    init = 1'b1;
    cyc();
    init = 1'b0;
    repeat (8) cyc();
    clear_n = 1'b0;
    #1;
    n_checks++;
    if (busy !== 1'b1 || rd_valid !== 2'b00 || rd_data !== 32'h0) begin
      n_fails++;
      $display("[TB] FAIL async_reset: busy=%b valid=%b data=%h, want busy=1 valid=00 data=0",
               busy, rd_valid, rd_data);
    end
    cyc();
    clear_n = 1'b1;
    n = 0;
    while (busy === 1'b1 && n < 40) begin
      cyc();
      n++;
    end
    n_checks++;
    if (n !== 16) begin
      n_fails++;
      $display("[TB] FAIL restart_sweep_len: busy cycles=%0d, want 16", n);
    end
    rd_en = 2'b11; rd_addr = 8'hF4;
    cyc();
    n_checks++;
    if (rd_data !== 32'h0 || rd_valid !== 2'b11) begin
      n_fails++;
      $display("[TB] FAIL restart_read: data=%h valid=%b, want 0 valid=11", rd_data, rd_valid);
    end
    idle_inputs();
  endtask

  initial begin
    n_checks = 0;
    n_fails  = 0;
    test_reset();
    test_write_read();
    test_bypass();
    test_dual_read();
    test_back_to_back();
    test_init_sweep();
    test_reset_mid_sweep();
    cyc();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
